// File: rtl/find_pivot_row.sv
// Simplex ratio test: picks the leaving row with the minimum ratio rhs/elem over elem > 0.
// Define FIND_PIVOT_ROW_PIPE_EN to register the cross products in an extra MUL state.
module find_pivot_row #(
    parameter int DATA_WIDTH    = 32,
    parameter int ROW_IDX_WIDTH = 16
) (
    input  logic                       clk,
    input  logic                       areset_n,
    input  logic                       start,
    input  logic [ROW_IDX_WIDTH-1:0]   num_rows,
    input  logic [2*DATA_WIDTH-1:0]    fifo_data,
    input  logic                       fifo_empty,
    output logic                       fifo_rd_en,
    output logic [ROW_IDX_WIDTH-1:0]   pivot_row,
    output logic [DATA_WIDTH-1:0]      pivot_elem,
    output logic                       found_pivot_row,
    output logic                       unbounded,
    output logic                       busy,
    output logic                       done
);

    localparam int PW = 2 * DATA_WIDTH;

    typedef enum logic [2:0] {
        S_IDLE,
        S_SCAN,
`ifdef FIND_PIVOT_ROW_PIPE_EN
        S_MUL,
`endif
        S_EVAL,
        S_DONE
    } state_t;

    state_t state_q, state_d;

    logic [ROW_IDX_WIDTH-1:0]     num_rows_q, num_rows_d;
    logic [ROW_IDX_WIDTH-1:0]     cnt_q, cnt_d;
    logic                         best_valid_q, best_valid_d;
    logic [ROW_IDX_WIDTH-1:0]     best_row_q, best_row_d;
    logic signed [DATA_WIDTH-1:0] best_elem_q, best_elem_d;
    logic signed [DATA_WIDTH-1:0] best_rhs_q, best_rhs_d;
    logic signed [DATA_WIDTH-1:0] cand_elem_q, cand_elem_d;
    logic signed [DATA_WIDTH-1:0] cand_rhs_q, cand_rhs_d;

    logic [ROW_IDX_WIDTH-1:0]     pivot_row_q, pivot_row_d;
    logic [DATA_WIDTH-1:0]        pivot_elem_q, pivot_elem_d;
    logic                         found_q, found_d;
    logic                         unbounded_q, unbounded_d;
    logic                         done_q, done_d;

    logic signed [PW-1:0] prod_a, prod_b;
    logic signed [PW-1:0] cmp_a, cmp_b;
    logic                 fin;

    // Both denominators are positive, so a/b < c/d  <=>  a*d < c*b.
    assign prod_a = PW'(cand_rhs_q) * PW'(best_elem_q);
    assign prod_b = PW'(best_rhs_q) * PW'(cand_elem_q);

`ifdef FIND_PIVOT_ROW_PIPE_EN
    logic signed [PW-1:0] prod_a_q, prod_a_d;
    logic signed [PW-1:0] prod_b_q, prod_b_d;

    assign prod_a_d = prod_a;
    assign prod_b_d = prod_b;
    assign cmp_a    = prod_a_q;
    assign cmp_b    = prod_b_q;

    always_ff @(posedge clk or negedge areset_n) begin
        if (!areset_n) begin
            prod_a_q <= '0;
            prod_b_q <= '0;
        end else begin
            prod_a_q <= prod_a_d;
            prod_b_q <= prod_b_d;
        end
    end
`else
    assign cmp_a = prod_a;
    assign cmp_b = prod_b;
`endif

    always_comb begin
        state_d      = state_q;
        num_rows_d   = num_rows_q;
        cnt_d        = cnt_q;
        best_valid_d = best_valid_q;
        best_row_d   = best_row_q;
        best_elem_d  = best_elem_q;
        best_rhs_d   = best_rhs_q;
        cand_elem_d  = cand_elem_q;
        cand_rhs_d   = cand_rhs_q;
        pivot_row_d  = pivot_row_q;
        pivot_elem_d = pivot_elem_q;
        found_d      = found_q;
        unbounded_d  = unbounded_q;
        done_d       = done_q;
        fifo_rd_en   = 1'b0;
        fin          = 1'b0;

        if (start) begin
            num_rows_d   = num_rows;
            cnt_d        = '0;
            best_valid_d = 1'b0;
            best_row_d   = '0;
            best_elem_d  = '0;
            best_rhs_d   = '0;
            pivot_row_d  = '0;
            pivot_elem_d = '0;
            found_d      = 1'b0;
            unbounded_d  = 1'b0;
            done_d       = 1'b0;
            state_d      = (num_rows == '0) ? S_DONE : S_SCAN;
        end else begin
            unique case (state_q)
                S_IDLE: ;
                S_SCAN: begin
                    if (!fifo_empty) begin
                        fifo_rd_en  = 1'b1;
                        cand_elem_d = fifo_data[PW-1:DATA_WIDTH];
                        cand_rhs_d  = fifo_data[DATA_WIDTH-1:0];
`ifdef FIND_PIVOT_ROW_PIPE_EN
                        state_d     = S_MUL;
`else
                        state_d     = S_EVAL;
`endif
                    end
                end
`ifdef FIND_PIVOT_ROW_PIPE_EN
                S_MUL: state_d = S_EVAL;
`endif
                S_EVAL: begin
                    // Strict less-than keeps the lowest index on ties.
                    if (cand_elem_q > 0 &&
                        (!best_valid_q || cmp_a < cmp_b)) begin
                        best_valid_d = 1'b1;
                        best_row_d   = cnt_q;
                        best_elem_d  = cand_elem_q;
                        best_rhs_d   = cand_rhs_q;
                    end
                    cnt_d = cnt_q + ROW_IDX_WIDTH'(1);
                    if (cnt_d == num_rows_q) begin
                        state_d = S_DONE;
                        fin     = 1'b1;
                    end else begin
                        state_d = S_SCAN;
                    end
                end
                S_DONE: fin = 1'b1;
                default: state_d = S_IDLE;
            endcase
        end

        if (fin) begin
            done_d       = 1'b1;
            found_d      = best_valid_d;
            unbounded_d  = ~best_valid_d;
            pivot_row_d  = best_row_d;
            pivot_elem_d = best_elem_d;
        end
    end

    always_ff @(posedge clk or negedge areset_n) begin
        if (!areset_n) begin
            state_q      <= S_IDLE;
            num_rows_q   <= '0;
            cnt_q        <= '0;
            best_valid_q <= 1'b0;
            best_row_q   <= '0;
            best_elem_q  <= '0;
            best_rhs_q   <= '0;
            cand_elem_q  <= '0;
            cand_rhs_q   <= '0;
            pivot_row_q  <= '0;
            pivot_elem_q <= '0;
            found_q      <= 1'b0;
            unbounded_q  <= 1'b0;
            done_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            num_rows_q   <= num_rows_d;
            cnt_q        <= cnt_d;
            best_valid_q <= best_valid_d;
            best_row_q   <= best_row_d;
            best_elem_q  <= best_elem_d;
            best_rhs_q   <= best_rhs_d;
            cand_elem_q  <= cand_elem_d;
            cand_rhs_q   <= cand_rhs_d;
            pivot_row_q  <= pivot_row_d;
            pivot_elem_q <= pivot_elem_d;
            found_q      <= found_d;
            unbounded_q  <= unbounded_d;
            done_q       <= done_d;
        end
    end

    assign pivot_row       = pivot_row_q;
    assign pivot_elem      = pivot_elem_q;
    assign found_pivot_row = found_q;
    assign unbounded       = unbounded_q;
    assign done            = done_q;
    assign busy            = (state_q != S_IDLE) && (state_q != S_DONE);

endmodule

// File: tb/tb_find_pivot_row.sv
// Directed bench for find_pivot_row: vector table plus reset and stall sequences.
module tb_find_pivot_row;

    logic        clk = 1'b0;
    logic        areset_n;
    logic        start;
    logic [15:0] num_rows;
    logic [63:0] fifo_data;
    logic        fifo_empty;
    logic        fifo_rd_en;
    logic [15:0] pivot_row;
    logic [31:0] pivot_elem;
    logic        found_pivot_row;
    logic        unbounded;
    logic        busy;
    logic        done;

    always #5 clk = ~clk;

    find_pivot_row #(.DATA_WIDTH(32), .ROW_IDX_WIDTH(16)) dut (
        .clk(clk), .areset_n(areset_n), .start(start),
        .num_rows(num_rows), .fifo_data(fifo_data),
        .fifo_empty(fifo_empty), .fifo_rd_en(fifo_rd_en),
        .pivot_row(pivot_row), .pivot_elem(pivot_elem),
        .found_pivot_row(found_pivot_row), .unbounded(unbounded),
        .busy(busy), .done(done)
    );

`ifdef FIND_PIVOT_ROW_PIPE_EN
    localparam int PER_ROW = 3;
`else
    localparam int PER_ROW = 2;
`endif

    // FWFT FIFO model; wg holds empty cycles to show before a word.
    logic [63:0] wd [16];
    int          wg [16];
    int          rp, wp;
    int          pops, viol;
    logic        rd_s;

    assign fifo_empty = (rp == wp) || (wg[rp] != 0);
    assign fifo_data  = wd[rp];

    typedef struct packed {
        int               n;
        logic [3:0][31:0] e;
        logic [3:0][31:0] r;
        int               gap_row;
        int               stall;
        int               er;
        logic [31:0]      ee;
        logic             ef;
    } vec_t;

    vec_t tv [9];
    int   ncmp = 0;
    int   nbad = 0;

    function automatic vec_t mk(int n, int e0, int r0, int e1, int r1,
                                int e2, int r2, int e3, int r3,
                                int gr, int st, int er, int ee, bit ef);
        vec_t v;
        v.n = n;
        v.e[0] = e0; v.r[0] = r0;
        v.e[1] = e1; v.r[1] = r1;
        v.e[2] = e2; v.r[2] = r2;
        v.e[3] = e3; v.r[3] = r3;
        v.gap_row = gr;
        v.stall   = st;
        v.er = er;
        v.ee = ee;
        v.ef = ef;
        return v;
    endfunction

    task automatic chk(input string nm, input logic [63:0] act,
                       input logic [63:0] exp);
        ncmp++;
        if (act !== exp) begin
            nbad++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic tick();
        @(negedge clk);
        rd_s = fifo_rd_en;
        if (fifo_rd_en && fifo_empty) viol++;
        @(posedge clk);
        #1;
        if (rd_s) begin
            rp++;
            pops++;
        end else if (rp != wp && wg[rp] > 0) begin
            wg[rp]--;
        end
    endtask

    task automatic load(input vec_t v);
        rp = 0;
        wp = 0;
        for (int i = 0; i < v.n; i++) begin
            wd[i] = {v.e[i], v.r[i]};
            wg[i] = (i == v.gap_row && v.stall > 0) ? v.stall + 1 : 0;
        end
        wp = v.n;
        pops = 0;
        viol = 0;
    endtask

    task automatic run_vec(input int k, input vec_t v);
        int lat;
        int exp_lat;
        string s;
        load(v);
        num_rows = 16'(v.n);
        start = 1'b1;
        tick();
        start = 1'b0;
        s = $sformatf("v%0d", k);
        chk({s, " done_cleared"}, 64'(done), 64'd0);
        chk({s, " busy_start"}, 64'(busy), 64'(v.n != 0));
        lat = 0;
        while (!done && lat < 200) begin
            tick();
            lat++;
        end
        exp_lat = (v.n == 0) ? 1 : PER_ROW * v.n + v.stall;
        chk({s, " latency"}, 64'(lat), 64'(exp_lat));
        chk({s, " done"}, 64'(done), 64'd1);
        chk({s, " pivot_row"}, 64'(pivot_row), 64'(v.er));
        chk({s, " pivot_elem"}, 64'(pivot_elem), 64'(v.ee));
        chk({s, " found"}, 64'(found_pivot_row), 64'(v.ef));
        chk({s, " unbounded"}, 64'(unbounded), 64'(!v.ef));
        chk({s, " busy_done"}, 64'(busy), 64'd0);
        tick();
        tick();
        chk({s, " done_held"}, 64'(done), 64'd1);
        chk({s, " pops"}, 64'(pops), 64'(v.n));
        chk({s, " rd_while_empty"}, 64'(viol), 64'd0);
    endtask

    initial begin
        tv[0] = mk(3, 2, 8, 4, 8, 1, 5, 0, 0, 0, 0, 1, 4, 1);
        tv[1] = mk(2, 1, 3, 2, 6, 0, 0, 0, 0, 0, 0, 0, 1, 1);
        tv[2] = mk(3, -1, 4, 0, 2, -3, 1, 0, 0, 0, 0, 0, 0, 0);
        tv[3] = mk(3, 2, 8, 4, 8, 1, 5, 0, 0, 2, 5, 1, 4, 1);
        tv[4] = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        tv[5] = mk(2, 2, -4, 1, 3, 0, 0, 0, 0, 0, 0, 0, 2, 1);
        tv[6] = mk(2, 3, 7, 5, 11, 0, 0, 0, 0, 0, 0, 1, 5, 1);
        tv[7] = mk(4, 0, 5, 3, 9, -2, 1, 1, 2, 0, 0, 3, 1, 1);
        tv[8] = mk(2, 32'h4000_0000, 32'h7fff_ffff, 1, 1,
                   0, 0, 0, 0, 0, 0, 1, 1, 1);

        rp = 0; wp = 0; pops = 0; viol = 0; rd_s = 1'b0;
        for (int i = 0; i < 16; i++) begin
            wd[i] = '0;
            wg[i] = 0;
        end
        areset_n = 1'b0;
        start    = 1'b0;
        num_rows = '0;
        tick();
        tick();
        chk("rst done", 64'(done), 64'd0);
        chk("rst busy", 64'(busy), 64'd0);
        chk("rst unbounded", 64'(unbounded), 64'd0);
        chk("rst found", 64'(found_pivot_row), 64'd0);
        chk("rst pivot_row", 64'(pivot_row), 64'd0);
        chk("rst pivot_elem", 64'(pivot_elem), 64'd0);
        areset_n = 1'b1;
        tick();

        for (int k = 0; k < 9; k++) run_vec(k, tv[k]);

        // Reset while row 1 is being popped, then rerun the first scenario.
        load(tv[0]);
        num_rows = 16'd3;
        start = 1'b1;
        tick();
        start = 1'b0;
        for (int i = 0; i < PER_ROW; i++) tick();
        chk("mid rd_en_before", 64'(fifo_rd_en), 64'd1);
        chk("mid busy_before", 64'(busy), 64'd1);
        areset_n = 1'b0;
        #1;
        chk("mid rd_en_async", 64'(fifo_rd_en), 64'd0);
        chk("mid busy_async", 64'(busy), 64'd0);
        chk("mid done_async", 64'(done), 64'd0);
        chk("mid pivot_row_async", 64'(pivot_row), 64'd0);
        tick();
        areset_n = 1'b1;
        tick();
        chk("mid idle_after", 64'(busy), 64'd0);
        run_vec(100, tv[0]);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nbad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/find_pivot_row.md
# find_pivot_row

Simplex ratio-test stage that sits directly downstream of the pivot-column search. Once the entering column is known, the column buffer streams one `{pivot-column element, RHS}` pair per constraint row through a first-word-fall-through FIFO. The block selects the leaving row with the minimum positive ratio `rhs/elem`, using a signed cross-multiply comparison so that no divider is needed. It reports the row index and pivot element to the row-normalization stage, or flags the problem as unbounded.

## Interface
- `DATA_WIDTH`, 32: signed fixed-point width of the element and of the RHS.
- `ROW_IDX_WIDTH`, 16: width of the row index and row count.
- `clk` in 1: single clock, rising edge.
- `areset_n` in 1: asynchronous, active-low reset.
- `start` in 1: single-cycle pulse; latches `num_rows` and begins a scan.
- `num_rows` in ROW_IDX_WIDTH: number of constraint rows to scan.
- `fifo_data` in 2*DATA_WIDTH: `[2*DATA_WIDTH-1:DATA_WIDTH]` = element, `[DATA_WIDTH-1:0]` = RHS; both signed. FWFT.
- `fifo_empty` in 1: FIFO has no valid word.
- `fifo_rd_en` out 1: pop; asserted only when `fifo_empty`=0.
- `pivot_row` out ROW_IDX_WIDTH: 0-based index of the selected row.
- `pivot_elem` out DATA_WIDTH: element of the selected row.
- `found_pivot_row` out 1: a row with element > 0 exists.
- `unbounded` out 1: no row with element > 0.
- `busy` out 1: a scan is in progress.
- `done` out 1: result valid; level, held until the next `start`.

## Operation
- States: IDLE, SCAN, EVAL, DONE. With `FIND_PIVOT_ROW_PIPE_EN` defined, a MUL state is added between SCAN and EVAL.
- IDLE:
  - On `start`, clear best-valid, the row counter, and all result outputs; latch `num_rows`.
  - If `num_rows`=0, go to DONE with `unbounded`=1. Otherwise go to SCAN.
- SCAN:
  - If `fifo_empty`=0: assert `fifo_rd_en` combinationally in the same cycle, capture the element and RHS into candidate registers, and go to EVAL (or MUL).
  - If `fifo_empty`=1: stay in SCAN with no pop.
- EVAL:
  - Candidates with element ≤ 0 are skipped.
  - Otherwise, compute the 2*DATA_WIDTH signed products `cand_rhs*best_elem` and `best_rhs*cand_elem`.
  - Replace best if best-valid=0 or `cand_rhs*best_elem < best_rhs*cand_elem`. This comparison is valid because both denominators are > 0.
  - Increment the row counter. If the counter equals `num_rows`, go to DONE; otherwise go to SCAN.
- Ties use strict less-than, so the lowest index wins.
- DONE:
  - `found_pivot_row` = best-valid; `unbounded` = ~best-valid.
  - `pivot_row` and `pivot_elem` come from the best registers; they are 0 if no best was found.
  - Remain in DONE until `start`.
- A `start` in any state aborts the current scan and restarts from IDLE semantics. Unread FIFO words are not flushed; the upstream stage owns the flush.
- Negative RHS values are compared arithmetically without special casing.
- Overflow cannot occur: the product width is exactly 2*DATA_WIDTH.

## Timing
- Reset values: all outputs 0, state IDLE, best-valid 0, counter 0.
- `areset_n` asserted mid-scan: outputs go to 0 immediately and `fifo_rd_en` deasserts asynchronously.
- Without PIPE:
  - 2 cycles per row with no stalls.
  - `done` rises 2·N cycles after the edge that samples `start` (N = `num_rows`).
- With PIPE: 3 cycles per row; `done` rises 3·N cycles after the `start` edge.
- `num_rows`=0: `done` rises 1 cycle after the `start` edge.
- `busy` is 1 in SCAN, MUL, and EVAL; 0 in IDLE and DONE.
- `fifo_rd_en` is at most one pulse per row and is never asserted in EVAL, MUL, DONE, or IDLE.
- FIFO stalls extend SCAN cycle-for-cycle and do not change the result.

## Configuration
- `FIND_PIVOT_ROW_PIPE_EN`:
  - Defined: the MUL state registers both products, and the EVAL comparison uses the registered products. This gives a shorter critical path for DATA_WIDTH ≥ 32 at a cost of 3 cycles per row.
  - Undefined: multiply and compare happen combinationally in EVAL, at 2 cycles per row.
  - Functional results are identical in both configurations.

## Test plan
- `num_rows`=3; rows (2,8), (4,8), (1,5) → ratios 4, 2, 5 → `pivot_row`=1, `pivot_elem`=4, `found_pivot_row`=1, `unbounded`=0. `done` at 6 cycles (9 with PIPE).
- Tie: rows (1,3), (2,6) → `pivot_row`=0, `pivot_elem`=1.
- Rows (-1,4), (0,2), (-3,1) → `found_pivot_row`=0, `unbounded`=1, `pivot_row`=0, `done`=1.
- Same data as the first scenario with `fifo_empty` held high for 5 cycles before row 2 → identical result; `done` is 5 cycles later; no `fifo_rd_en` while empty.
- `areset_n` low in the middle of row 1 → all outputs 0 in the same cycle. After release, a `start` with the first scenario's data gives `pivot_row`=1.
- `start` with `num_rows`=0 → `done`=1 and `unbounded`=1 one cycle later; zero pops.
